combi_encoder: RTL and testbench

- Streaming instruction encoder: converts abstract micro-op descriptors into 32-bit ARM or RISC-V machine words.
- The emitted words decode back to the same operation in the combined ARM/RISC-V decode stage.
- Used by the boot/self-test sequencer and by the verification harness to generate programs for either ISA.
- Multi-word ops (32-bit constant load) are expanded into an output word sequence under valid/ready flow control.

---
 rtl/combi_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_combi_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combi_encoder.sv
// combi_encoder: streaming micro-op to machine-word encoder for ARM and RISC-V.
// Each accepted descriptor expands into 1..4 32-bit words presented under
// valid/ready flow control; unencodable descriptors are consumed and flagged.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      descriptor handshake
//   in_arm                   1 = ARM, 0 = RISC-V
//   in_op, in_fn             operation (ALUR/ALUI/LW/SW/LI) and ALU function
//   in_rd, in_rs1, in_rs2    register fields
//   in_imm                   immediate / offset / constant
//   out_valid / out_ready    word handshake
//   out_instr, out_last      encoded word, final word of the descriptor
//   out_arm                  ISA of out_instr
//   err                      one-cycle pulse on an unencodable descriptor
module combi_encoder (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_arm,
  input  logic [2:0]         in_op,
  input  logic [2:0]         in_fn,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic signed [31:0] in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_last,
  output logic               out_arm,
  output logic               err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;

  logic               arm_p0;
  logic [2:0]         op_p0, fn_p0;
  logic [4:0]         rd_p0, rs1_p0, rs2_p0;
  logic signed [31:0] imm_p0;
  logic [1:0]         cnt, last_idx, cnt_nxt;
  logic               accept, in_bad, load, hs;

  function automatic logic [2:0] rv_f3(input logic [2:0] fn);
    case (fn)
      3'd2:    rv_f3 = 3'b111;
      3'd3:    rv_f3 = 3'b110;
      3'd4:    rv_f3 = 3'b100;
      default: rv_f3 = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] arm_opc(input logic [2:0] fn);
    case (fn)
      3'd1:    arm_opc = 4'b0010;
      3'd2:    arm_opc = 4'b0000;
      3'd3:    arm_opc = 4'b1100;
      3'd4:    arm_opc = 4'b0001;
      default: arm_opc = 4'b0100;
    endcase
  endfunction

  function automatic logic [31:0] arm_dp(input logic i, input logic [3:0] opc,
                                         input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [11:0] op2);
    arm_dp = {4'hE, 2'b00, i, opc, 1'b0, rn, rd, op2};
  endfunction

  function automatic logic rv_small(input logic signed [31:0] imm);
    rv_small = (imm >= -32'sd2048) && (imm <= 32'sd2047);
  endfunction

  function automatic logic bad_desc(input logic arm, input logic [2:0] op,
                                    input logic [2:0] fn, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic signed [31:0] imm);
    bad_desc = 1'b0;
    if (op > 3'd4) bad_desc = 1'b1;
    if ((op <= 3'd1) && (fn > 3'd4)) bad_desc = 1'b1;
    if (arm) begin
      if (rd[4] | rs1[4] | rs2[4]) bad_desc = 1'b1;
      if ((op == 3'd1) && ((imm < 32'sd0) || (imm > 32'sd255))) bad_desc = 1'b1;
      if (((op == 3'd2) || (op == 3'd3)) && ((imm < -32'sd4095) || (imm > 32'sd4095)))
        bad_desc = 1'b1;
    end else begin
      if ((op == 3'd1) && (fn == 3'd1)) bad_desc = 1'b1;
      if ((op >= 3'd1) && (op <= 3'd3) && !rv_small(imm)) bad_desc = 1'b1;
    end
  endfunction

  // Index of the final word: ARM constants always take four byte-wise steps,
  // RISC-V constants need LUI+ADDI only when they do not fit a 12-bit ADDI.
  function automatic logic [1:0] words_m1(input logic arm, input logic [2:0] op,
                                          input logic signed [31:0] imm);
    words_m1 = 2'd0;
    if (op == 3'd4) begin
      if (arm)                words_m1 = 2'd3;
      else if (!rv_small(imm)) words_m1 = 2'd1;
    end
  endfunction

  function automatic logic [31:0] encode(input logic arm, input logic [2:0] op,
                                         input logic [2:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic signed [31:0] imm,
                                         input logic [1:0] idx);
    logic [11:0] off12;
    logic [19:0] lui20;
    logic [3:0]  ls_rd;
    // Magnitude of the offset; only the low 12 bits matter once range-checked.
    off12 = imm[31] ? (~imm[11:0] + 12'd1) : imm[11:0];
    // LUI upper part pre-compensates for the sign extension of the ADDI low part.
    lui20 = imm[31:12] + {19'd0, imm[11]};
    ls_rd = (op == 3'd3) ? rs2[3:0] : rd[3:0];
    encode = '0;
    if (arm) begin
      case (op)
        3'd0: encode = arm_dp(1'b0, arm_opc(fn), rs1[3:0], rd[3:0], {8'd0, rs2[3:0]});
        3'd1: encode = arm_dp(1'b1, arm_opc(fn), rs1[3:0], rd[3:0], {4'd0, imm[7:0]});
        3'd2, 3'd3:
          encode = {4'hE, 2'b01, 1'b0, 1'b1, ~imm[31], 2'b00, (op == 3'd2),
                    rs1[3:0], ls_rd, off12};
        3'd4: begin
          case (idx)
            2'd0:    encode = arm_dp(1'b1, 4'b1101, 4'd0, rd[3:0], {4'd0, imm[7:0]});
            2'd1:    encode = arm_dp(1'b1, 4'b1100, rd[3:0], rd[3:0], {4'd12, imm[15:8]});
            2'd2:    encode = arm_dp(1'b1, 4'b1100, rd[3:0], rd[3:0], {4'd8, imm[23:16]});
            default: encode = arm_dp(1'b1, 4'b1100, rd[3:0], rd[3:0], {4'd4, imm[31:24]});
          endcase
        end
        default: encode = '0;
      endcase
    end else begin
      case (op)
        3'd0: encode = {(fn == 3'd1) ? 7'b0100000 : 7'b0000000, rs2, rs1, rv_f3(fn),
                        rd, 7'b0110011};
        3'd1: encode = {imm[11:0], rs1, rv_f3(fn), rd, 7'b0010011};
        3'd2: encode = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        3'd3: encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        3'd4: begin
          if (rv_small(imm))  encode = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
          else if (idx == 2'd0) encode = {lui20, rd, 7'b0110111};
          else                encode = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
        end
        default: encode = '0;
      endcase
    end
  endfunction

  assign out_valid = (state == EMIT);
  assign hs        = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (hs & out_last);
  assign accept    = in_valid & in_ready;
  assign in_bad    = bad_desc(in_arm, in_op, in_fn, in_rd, in_rs1, in_rs2, in_imm);
  assign load      = accept & ~in_bad;
  assign cnt_nxt   = cnt + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = EMIT;
      EMIT:    if (hs && out_last) state_nxt = load ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: descriptor held for the whole multi-word expansion
  always_ff @(posedge clk) begin
    if (load) begin
      arm_p0 <= in_arm;
      op_p0  <= in_op;
      fn_p0  <= in_fn;
      rd_p0  <= in_rd;
      rs1_p0 <= in_rs1;
      rs2_p0 <= in_rs2;
      imm_p0 <= in_imm;
    end
  end

  // Output word register: loaded directly from the inputs on accept so word 0
  // is ready the next cycle, then advanced from the held descriptor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 2'd0;
      last_idx  <= 2'd0;
      out_instr <= '0;
      out_last  <= 1'b0;
      out_arm   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept & in_bad;
      if (load) begin
        cnt       <= 2'd0;
        last_idx  <= words_m1(in_arm, in_op, in_imm);
        out_instr <= encode(in_arm, in_op, in_fn, in_rd, in_rs1, in_rs2, in_imm, 2'd0);
        out_last  <= (words_m1(in_arm, in_op, in_imm) == 2'd0);
        out_arm   <= in_arm;
      end else if (hs && !out_last) begin
        cnt       <= cnt_nxt;
        out_instr <= encode(arm_p0, op_p0, fn_p0, rd_p0, rs1_p0, rs2_p0, imm_p0, cnt_nxt);
        out_last  <= (cnt_nxt == last_idx);
      end
    end
  end

endmodule

// File: tb/tb_combi_encoder.sv
module tb_combi_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_arm;
  logic [2:0]  in_op, in_fn;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_last, out_arm, err;
  logic [31:0] out_instr;

  int checks = 0;
  int failures = 0;
  bit force_en = 1'b1;
  bit force_val = 1'b1;

  typedef struct {
    bit          is_err;
    logic [31:0] w;
    bit          last;
    bit          arm;
  } exp_t;

  exp_t sb[$];

  int rv_f3_tab [5] = '{0, 0, 7, 6, 4};
  int arm_op_tab [5] = '{4, 2, 0, 12, 1};
  int arm_rot_tab [4] = '{0, 12, 8, 4};

  combi_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_arm(in_arm),
    .in_op(in_op), .in_fn(in_fn), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_arm(out_arm), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (no matching expectation)", name);
  endtask

  // Field packers straight from the instruction-format tables.
  function automatic logic [31:0] rv_r(int f7, int rs2, int rs1, int f3, int rd, int opc);
    return 32'(f7) << 25 | 32'(rs2) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7 | 32'(opc);
  endfunction
  function automatic logic [31:0] rv_i(logic [31:0] imm, int rs1, int f3, int rd, int opc);
    return (imm & 32'hFFF) << 20 | 32'(rs1) << 15 | 32'(f3) << 12 | 32'(rd) << 7 | 32'(opc);
  endfunction
  function automatic logic [31:0] arm_dpw(int i, int opc, int rn, int rd, int op2);
    return 32'hE000_0000 | 32'(i) << 25 | 32'(opc) << 21 | 32'(rn) << 16 | 32'(rd) << 12 | 32'(op2);
  endfunction

  task automatic model(input bit arm, input logic [2:0] op_l, input logic [2:0] fn_l,
                       input logic [4:0] rd_l, input logic [4:0] rs1_l, input logic [4:0] rs2_l,
                       input logic [31:0] imm, output bit bad, output int n,
                       output logic [31:0] w [4]);
    int op, fn, rd, rs1, rs2, v, off;
    logic [31:0] hi;
    op = int'(op_l); fn = int'(fn_l); rd = int'(rd_l); rs1 = int'(rs1_l); rs2 = int'(rs2_l);
    v = $signed(imm);
    bad = 0; n = 1;
    for (int k = 0; k < 4; k++) w[k] = 32'd0;
    if (op > 4) bad = 1;
    if (op <= 1 && fn > 4) bad = 1;
    if (arm) begin
      if (rd > 15 || rs1 > 15 || rs2 > 15) bad = 1;
      if (op == 1 && (v < 0 || v > 255)) bad = 1;
      if ((op == 2 || op == 3) && (v < -4095 || v > 4095)) bad = 1;
    end else begin
      if (op == 1 && fn == 1) bad = 1;
      if (op >= 1 && op <= 3 && (v < -2048 || v > 2047)) bad = 1;
    end
    if (bad) return;
    if (!arm) begin
      case (op)
        0: w[0] = rv_r(fn == 1 ? 32 : 0, rs2, rs1, rv_f3_tab[fn], rd, 'h33);
        1: w[0] = rv_i(imm, rs1, rv_f3_tab[fn], rd, 'h13);
        2: w[0] = rv_i(imm, rs1, 2, rd, 'h03);
        3: w[0] = rv_r((v >> 5) & 'h7F, rs2, rs1, 2, v & 'h1F, 'h23);
        default: begin
          if (v >= -2048 && v <= 2047) w[0] = rv_i(imm, 0, 0, rd, 'h13);
          else begin
            n = 2;
            hi = (imm + 32'h800) >> 12;
            w[0] = hi << 12 | 32'(rd) << 7 | 32'h37;
            w[1] = rv_i(imm, rd, 0, rd, 'h13);
          end
        end
      endcase
    end else begin
      case (op)
        0: w[0] = arm_dpw(0, arm_op_tab[fn], rs1, rd, rs2);
        1: w[0] = arm_dpw(1, arm_op_tab[fn], rs1, rd, v);
        2, 3: begin
          off = (v < 0) ? -v : v;
          w[0] = 32'hE500_0000 | ((v >= 0) ? 32'h0080_0000 : 32'd0) |
                 ((op == 2) ? 32'h0010_0000 : 32'd0) | 32'(rs1) << 16 |
                 32'(op == 3 ? rs2 : rd) << 12 | 32'(off);
        end
        default: begin
          n = 4;
          w[0] = arm_dpw(1, 13, 0, rd, int'((imm >> 0) & 32'hFF));
          for (int k = 1; k < 4; k++)
            w[k] = arm_dpw(1, 12, rd, rd, arm_rot_tab[k] * 256 + int'((imm >> (8 * k)) & 32'hFF));
        end
      endcase
    end
  endtask

  task automatic junk_fields();
    in_arm = 1'($urandom_range(0, 1));
    in_op  = 3'($urandom_range(0, 7));
    in_fn  = 3'($urandom_range(0, 7));
    in_rd  = 5'($urandom_range(0, 31));
    in_rs1 = 5'($urandom_range(0, 31));
    in_rs2 = 5'($urandom_range(0, 31));
    in_imm = $urandom();
  endtask

  // Present one descriptor from a falling edge; returns at accept edge + 1.
  task automatic send(input bit arm, input logic [2:0] op, input logic [2:0] fn,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    bit bad, acc;
    int n, waited;
    logic [31:0] w [4];
    exp_t e;
    model(arm, op, fn, rd, rs1, rs2, imm, bad, n, w);
    @(negedge clk);
    in_valid = 1'b1; in_arm = arm; in_op = op; in_fn = fn;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    acc = 0; waited = 0;
    while (!acc && waited < 200) begin
      #1;
      if (in_ready) acc = 1;
      else begin @(negedge clk); waited++; end
    end
    if (!acc) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    if (bad) begin
      e.is_err = 1; e.w = 32'd0; e.last = 0; e.arm = 0;
      sb.push_back(e);
    end else begin
      for (int k = 0; k < n; k++) begin
        e.is_err = 0; e.w = w[k]; e.last = (k == n - 1); e.arm = arm;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (bad) chk("bad_no_valid", {31'd0, out_valid}, 32'd0);
    else begin
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      chk("first_word", out_instr, w[0]);
    end
  endtask

  // Monitor / scoreboard: every output handshake and err pulse pops one entry.
  initial begin
    exp_t e;
    logic [31:0] pi;
    bit pstall;
    pstall = 0; pi = 32'd0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
      #2;
      if (!rst) pstall = 0;
      else begin
        if (pstall && out_valid) chk("hold_instr", out_instr, pi);
        if (err) begin
          if (sb.size() == 0) fail("err_unexpected");
          else begin
            e = sb.pop_front();
            chk("err_expected", {31'd0, e.is_err}, 32'd1);
          end
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail("word_unexpected");
          else begin
            e = sb.pop_front();
            if (e.is_err) fail("word_instead_of_err");
            else begin
              chk("word", out_instr, e.w);
              chk("last", {31'd0, out_last}, {31'd0, e.last});
              chk("arm", {31'd0, out_arm}, {31'd0, e.arm});
            end
          end
        end
        pstall = out_valid & ~out_ready;
        pi = out_instr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    bit arm;
    logic [2:0] op, fn;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    rst = 1'b0;
    in_valid = 1'b0;
    junk_fields();
    #22;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_arm", {31'd0, out_arm}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b1;

    send(0, 0, 0, 3, 1, 2, 32'd0);
    chk("rv_add", out_instr, 32'h002081B3);
    chk("rv_add_last", {31'd0, out_last}, 32'd1);
    chk("rv_add_arm", {31'd0, out_arm}, 32'd0);

    send(0, 4, 0, 5, 0, 0, 32'h12345FFF);
    chk("rv_li_w0", out_instr, 32'h123462B7);
    chk("rv_li_w0_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1;
    chk("rv_li_w1", out_instr, 32'hFFF28293);
    chk("rv_li_w1_last", {31'd0, out_last}, 32'd1);

    send(1, 4, 0, 2, 0, 0, 32'h11223344);
    chk("arm_li_w0", out_instr, 32'hE3A02044);
    @(posedge clk); #1;
    force_val = 1'b0;
    repeat (3) begin
      chk("arm_li_stall_w1", out_instr, 32'hE3822C33);
      chk("arm_li_stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    force_val = 1'b1;

    send(1, 2, 0, 1, 0, 0, 32'hFFFF_FFF8);
    chk("arm_lw", out_instr, 32'hE5101008);

    send(0, 1, 1, 1, 1, 0, 32'd5);
    chk("rv_alui_sub_err", {31'd0, err}, 32'd1);
    send(1, 0, 0, 16, 1, 2, 32'd0);
    chk("arm_rd16_err", {31'd0, err}, 32'd1);

    force_val = 1'b0;
    send(0, 4, 0, 5, 0, 0, 32'h12345FFF);
    force_val = 1'b1;
    @(posedge clk); #1;
    force_val = 1'b0;
    chk("rst_test_w1", out_instr, 32'hFFF28293);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    force_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        junk_fields();
      end
      arm = 1'($urandom_range(0, 1));
      op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      fn  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rd  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      rs1 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      rs2 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 256));
        1:       imm = 32'($urandom_range(0, 4097)) - 32'd2049;
        2:       imm = 32'($urandom_range(0, 8193)) - 32'd4097;
        default: imm = $urandom();
      endcase
      send(arm, op, fn, rd, rs1, rs2, imm);
      junk_fields();
    end

    force_en = 1'b1;
    force_val = 1'b1;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    #10;
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
